// File: rtl/irq_router_pkg.sv
// Shared constants for the irq_router CSR block: register offsets, TYPE/POL encodings
// and bank sizing.
package irq_router_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ENABLE = 2'd1;
    localparam logic [1:0] REG_TYPE   = 2'd2;
    localparam logic [1:0] REG_POL    = 2'd3;

    localparam int unsigned REGS_PER_BANK = 4;

    localparam logic TYPE_LEVEL = 1'b0;
    localparam logic TYPE_EDGE  = 1'b1;
    localparam logic POL_HIGH   = 1'b0;
    localparam logic POL_LOW    = 1'b1;

    // Number of 8-channel register banks needed for n channels.
    function automatic int unsigned bank_count(input int unsigned n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// Single-channel input filter: the output follows the input only after the input has
// differed from it for DEBOUNCE_CNT consecutive ce ticks.
module irq_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_d;

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout;
        if (ce) begin
            if (din != dout) begin
                if (cnt_q == LAST) begin
                    dout_d = din;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                // Any bounce back to the current output restarts the count.
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            dout  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dout  <= dout_d;
        end
    end

endmodule

// File: rtl/irq_router.sv
// CSR-mapped interrupt aggregator with per-channel level/edge type, polarity, enable and
// W1C status. Define IRQ_DEBOUNCE_EN to insert a per-channel debounce filter before POL.
module irq_router
    import irq_router_pkg::*;
#(
    parameter logic [4:0]          BASE_ADDR    = 5'h1c,
    parameter int unsigned         NUM_INTS     = 8,
    parameter logic [NUM_INTS-1:0] DFL_ENABLE   = '0,
    parameter logic [NUM_INTS-1:0] DFL_TYPE     = '1,
    parameter logic [NUM_INTS-1:0] DFL_POL      = '0,
    parameter int unsigned         DEBOUNCE_CNT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] ints,
    output logic                irq
);

    localparam int unsigned NBANK = bank_count(NUM_INTS);
    localparam int unsigned PW    = NBANK * 8;
    localparam int unsigned NREG  = REGS_PER_BANK * NBANK;

    logic [NUM_INTS-1:0] status_q, status_d;
    logic [NUM_INTS-1:0] enable_q, enable_d;
    logic [NUM_INTS-1:0] type_q, type_d;
    logic [NUM_INTS-1:0] pol_q, pol_d;
    logic [NUM_INTS-1:0] prev_q;
    logic [NUM_INTS-1:0] filt;
    logic [NUM_INTS-1:0] s;
    logic [NUM_INTS-1:0] wsel, wdat, w1c;

    logic [4:0] offset;
    logic       hit;
    logic [2:0] bank;
    logic [1:0] reg_sel;

    logic [PW-1:0] wsel_pad, wdat_pad;
    logic [PW-1:0] status_pad, enable_pad, type_pad, pol_pad;

    // Source conditioning
`ifdef IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < NUM_INTS; i++) begin : g_deb
        irq_debounce #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .din (ints[i]),
            .dout(filt[i])
        );
    end
`else
    localparam int unsigned unused_deb_cnt = DEBOUNCE_CNT;
    logic unused_ce;
    assign unused_ce = ce;
    assign filt      = ints;
`endif

    assign s = filt ^ pol_q;

    // Address decode; offset wraps modulo the 5-bit bus like the address itself.
    assign offset  = csr_a - BASE_ADDR;
    assign hit     = (32'(offset) < NREG);
    assign bank    = offset[4:2];
    assign reg_sel = offset[1:0];

    always_comb begin
        wsel_pad = '0;
        wdat_pad = '0;
        for (int b = 0; b < int'(NBANK); b++) begin
            if (csr_we && hit && bank == 3'(b)) begin
                wsel_pad[b*8 +: 8] = 8'hff;
                wdat_pad[b*8 +: 8] = csr_di;
            end
        end
    end

    // Bits at or above NUM_INTS fall off here, so writes to them are ignored.
    assign wsel = wsel_pad[NUM_INTS-1:0];
    assign wdat = wdat_pad[NUM_INTS-1:0];
    assign w1c  = (reg_sel == REG_STATUS) ? (wsel & wdat) : '0;

    always_comb begin
        enable_d = enable_q;
        type_d   = type_q;
        pol_d    = pol_q;
        if (reg_sel == REG_ENABLE) enable_d = (enable_q & ~wsel) | (wdat & wsel);
        if (reg_sel == REG_TYPE)   type_d   = (type_q & ~wsel) | (wdat & wsel);
        if (reg_sel == REG_POL)    pol_d    = (pol_q & ~wsel) | (wdat & wsel);
    end

    // A new edge wins over a same-cycle W1C; level channels just track s.
    always_comb begin
        status_d = '0;
        for (int i = 0; i < int'(NUM_INTS); i++) begin
            if (type_q[i] == TYPE_EDGE) begin
                status_d[i] = (status_q[i] & ~w1c[i]) | (s[i] & ~prev_q[i]);
            end else begin
                status_d[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            enable_q <= DFL_ENABLE;
            type_q   <= DFL_TYPE;
            pol_q    <= DFL_POL;
            prev_q   <= s;
            irq      <= 1'b0;
        end else begin
            status_q <= status_d;
            enable_q <= enable_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            prev_q   <= s;
            irq      <= |(status_q & enable_q);
        end
    end

    // Read path
    always_comb begin
        status_pad                 = '0;
        enable_pad                 = '0;
        type_pad                   = '0;
        pol_pad                    = '0;
        status_pad[NUM_INTS-1:0]   = status_q;
        enable_pad[NUM_INTS-1:0]   = enable_q;
        type_pad[NUM_INTS-1:0]     = type_q;
        pol_pad[NUM_INTS-1:0]      = pol_q;
    end

    always_comb begin
        csr_do = 8'h00;
        for (int b = 0; b < int'(NBANK); b++) begin
            if (hit && bank == 3'(b)) begin
                unique case (reg_sel)
                    REG_STATUS: csr_do = status_pad[b*8 +: 8];
                    REG_ENABLE: csr_do = enable_pad[b*8 +: 8];
                    REG_TYPE:   csr_do = type_pad[b*8 +: 8];
                    REG_POL:    csr_do = pol_pad[b*8 +: 8];
                    default:    csr_do = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_router.sv
// Randomized bench for irq_router: an 8-channel and a 12-channel instance share one CSR
// bus and source vector and are both compared every cycle against a behavioural model.
module tb_irq_router;
    import irq_router_pkg::*;

`ifdef IRQ_DEBOUNCE_EN
    localparam bit USE_DEB = 1'b1;
`else
    localparam bit USE_DEB = 1'b0;
`endif
    localparam int DEB_CNT = 3;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [4:0]  csr_a;
    logic [7:0]  csr_di;
    logic        csr_we;
    logic [7:0]  csr_do_a, csr_do_b;
    logic [11:0] ints;
    logic        irq_a, irq_b;

    irq_router #(
        .BASE_ADDR   (5'h1c),
        .NUM_INTS    (8),
        .DEBOUNCE_CNT(DEB_CNT)
    ) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .csr_a (csr_a),
        .csr_di(csr_di),
        .csr_we(csr_we),
        .csr_do(csr_do_a),
        .ints  (ints[7:0]),
        .irq   (irq_a)
    );

    irq_router #(
        .BASE_ADDR   (5'h04),
        .NUM_INTS    (12),
        .DFL_ENABLE  (12'h801),
        .DFL_TYPE    (12'hf0f),
        .DFL_POL     (12'h00c),
        .DEBOUNCE_CNT(DEB_CNT)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .csr_a (csr_a),
        .csr_di(csr_di),
        .csr_we(csr_we),
        .csr_do(csr_do_b),
        .ints  (ints),
        .irq   (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, index 0 = 8-channel instance, 1 = 12-channel instance.
    int          m_n[2];
    logic [4:0]  m_base[2];
    logic [15:0] m_dfl_en[2], m_dfl_type[2], m_dfl_pol[2];
    logic [15:0] m_status[2], m_en[2], m_type[2], m_pol[2], m_prev[2], m_filt[2];
    logic        m_irq[2];
    int          m_cnt[2][16];

    function automatic logic [7:0] mread(input int k, input logic [4:0] a);
        int          off;
        int          nb;
        logic [15:0] v;
        off = int'(5'(a - m_base[k]));
        nb  = (m_n[k] + 7) / 8;
        if (off >= 4 * nb) return 8'h00;
        case (off % 4)
            0:       v = m_status[k];
            1:       v = m_en[k];
            2:       v = m_type[k];
            default: v = m_pol[k];
        endcase
        return 8'(v >> (8 * (off / 4)));
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] nm, fin, s, wm, dat, w1c, nxt;
            int          off, nb, bank, r;
            nm  = 16'((32'd1 << m_n[k]) - 1);
            fin = USE_DEB ? m_filt[k] : {4'b0, ints};
            s   = (fin ^ m_pol[k]) & nm;
            if (rst) begin
                m_status[k] = '0;
                m_en[k]     = m_dfl_en[k];
                m_type[k]   = m_dfl_type[k];
                m_pol[k]    = m_dfl_pol[k];
                m_prev[k]   = s;
                m_irq[k]    = 1'b0;
                m_filt[k]   = '0;
                for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
            end else begin
                off  = int'(5'(csr_a - m_base[k]));
                nb   = (m_n[k] + 7) / 8;
                bank = off / 4;
                r    = off % 4;
                dat  = 16'({8'h00, csr_di} << (8 * bank)) & nm;
                wm   = (csr_we && off < 4 * nb) ? (16'(16'h00ff << (8 * bank)) & nm) : 16'h0;
                w1c  = (r == 0) ? (wm & dat) : 16'h0;
                m_irq[k] = |(m_status[k] & m_en[k]);
                // Edge channels: sticky rising-of-s detect, cleared by W1C unless re-set.
                nxt = (((m_status[k] & ~w1c) | (s & ~m_prev[k])) & m_type[k]) | (s & ~m_type[k]);
                m_status[k] = nxt & nm;
                m_prev[k]   = s;
                if (r == 1) m_en[k]   = (m_en[k] & ~wm) | (dat & wm);
                if (r == 2) m_type[k] = (m_type[k] & ~wm) | (dat & wm);
                if (r == 3) m_pol[k]  = (m_pol[k] & ~wm) | (dat & wm);
                if (ce) begin
                    for (int i = 0; i < m_n[k]; i++) begin
                        if (ints[i] != m_filt[k][i]) begin
                            m_cnt[k][i]++;
                            if (m_cnt[k][i] == DEB_CNT) begin
                                m_filt[k][i] = ints[i];
                                m_cnt[k][i]  = 0;
                            end
                        end else begin
                            m_cnt[k][i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("irq_a", irq_a, m_irq[0]);
        check_eq("irq_b", irq_b, m_irq[1]);
        check_eq("csr_do_a", csr_do_a, mread(0, csr_a));
        check_eq("csr_do_b", csr_do_b, mread(1, csr_a));
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input int k, input logic [4:0] a, input logic [7:0] exp, input string tag);
        csr_a  = a;
        csr_we = 1'b0;
        #1;
        check_eq(tag, (k == 0) ? csr_do_a : csr_do_b, exp);
    endtask

    initial begin
        m_n[0] = 8;   m_base[0] = 5'h1c;
        m_n[1] = 12;  m_base[1] = 5'h04;
        m_dfl_en[0] = 16'h0000; m_dfl_type[0] = 16'h00ff; m_dfl_pol[0] = 16'h0000;
        m_dfl_en[1] = 16'h0801; m_dfl_type[1] = 16'h0f0f; m_dfl_pol[1] = 16'h000c;
        for (int k = 0; k < 2; k++) begin
            m_status[k] = '0;
            m_en[k]     = m_dfl_en[k];
            m_type[k]   = m_dfl_type[k];
            m_pol[k]    = m_dfl_pol[k];
            m_prev[k]   = '0;
            m_filt[k]   = '0;
            m_irq[k]    = 1'b0;
            for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
        end

        rst = 1'b1; ce = 1'b0; csr_a = '0; csr_di = '0; csr_we = 1'b0; ints = '0;
        repeat (3) tick();
        rst = 1'b0;

        rd(0, 5'h1c, 8'h00, "rst_status");
        rd(0, 5'h1d, 8'h00, "rst_enable");
        rd(0, 5'h1e, 8'hff, "rst_type");
        rd(0, 5'h1f, 8'h00, "rst_pol");
        check_eq("rst_irq", irq_a, 1'b0);
        tick();
        rd(0, 5'h1c, 8'h00, "rst_no_edge");

        wr(5'h09, 8'hff);
        rd(1, 5'h09, 8'h0f, "b_enable_bank1");
        rd(1, 5'h0c, 8'h00, "b_out_of_range");
        rd(1, 5'h05, 8'h01, "b_enable_bank0");
        rd(0, 5'h09, 8'h00, "a_out_of_range");
        tick();

`ifndef IRQ_DEBOUNCE_EN
        // Edge channel 0
        wr(5'h1d, 8'h01);
        ints[0] = 1'b1;
        tick();
        rd(0, 5'h1c, 8'h01, "edge_status");
        check_eq("edge_irq_lag", irq_a, 1'b0);
        tick();
        check_eq("edge_irq", irq_a, 1'b1);
        wr(5'h1c, 8'h01);
        check_eq("w1c_irq_lag", irq_a, 1'b1);
        rd(0, 5'h1c, 8'h00, "w1c_status");
        tick();
        check_eq("w1c_irq", irq_a, 1'b0);

        // Level channel 3, active low
        wr(5'h1e, 8'hf7);
        wr(5'h1f, 8'h08);
        wr(5'h1d, 8'h09);
        rd(0, 5'h1c, 8'h08, "level_status");
        tick();
        check_eq("level_irq", irq_a, 1'b1);
        wr(5'h1c, 8'h08);
        rd(0, 5'h1c, 8'h08, "level_w1c_hold");
        ints[3] = 1'b1;
        tick();
        rd(0, 5'h1c, 8'h00, "level_clear");
        tick();
        check_eq("level_irq_drop", irq_a, 1'b0);

        // Edge on channel 1 coincident with its W1C
        wr(5'h1d, 8'h0b);
        ints[1] = 1'b1;
        tick();
        tick();
        check_eq("ch1_irq", irq_a, 1'b1);
        ints[1] = 1'b0;
        tick();
        ints[1] = 1'b1;
        csr_a = 5'h1c; csr_di = 8'h02; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
        rd(0, 5'h1c, 8'h02, "ch1_set_w1c");
        check_eq("ch1_irq_hold", irq_a, 1'b1);
        tick();
        check_eq("ch1_irq_hold2", irq_a, 1'b1);
        wr(5'h1c, 8'hff);
`else
        ce = 1'b1;
        wr(5'h1d, 8'h04);
        ints[2] = 1'b1;
        tick();
        tick();
        ints[2] = 1'b0;
        repeat (4) tick();
        rd(0, 5'h1c, 8'h00, "deb_pulse_rejected");
        ints[2] = 1'b1;
        repeat (4) tick();
        rd(0, 5'h1c, 8'h04, "deb_hold_accepted");
        tick();
`endif

        for (int n = 0; n < 3000; n++) begin
            int sel;
            ce  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 299) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0, 3:    csr_a = 5'(5'h1c + 5'($urandom_range(0, 3)));
                1:       csr_a = 5'(5'h04 + 5'($urandom_range(0, 7)));
                default: csr_a = 5'($urandom);
            endcase
            csr_we = ($urandom_range(0, 3) == 0);
            csr_di = 8'($urandom);
            ints   = ints ^ 12'($urandom & $urandom & $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
